// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        END   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs; head is read straight from the
// entry registers so a pushed entry is visible the cycle after the push edge.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    // Guards make the FIFO safe even if a caller over-pushes or over-pops.
    assign w_do_push = i_push && !i_flush && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !i_flush && !o_empty;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_mem[gi] <= '0;
                end else if (w_do_push && (r_wr_ptr == AW'(gi))) begin
                    r_mem[gi] <= i_entry;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch PC, end-of-memory / fault FSM and redirect handling in front of the
// prefetch queue that feeds decode.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fault,
    output logic [1:0]  state_o
);

    localparam logic [31:0] LAST_PC = 32'((MEM_WORDS - 1) * WORD_BYTES);
    localparam logic [31:0] END_PC  = 32'(MEM_WORDS * WORD_BYTES);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic         r_fault;

    fetch_entry_t w_head;
    fetch_entry_t w_entry;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push;
    logic         w_flush;
    logic         w_in_range;

    assign w_in_range = (r_fetch_pc < END_PC);
    assign inst_valid = !w_empty && (r_state != FAULT);
    assign w_pop      = inst_valid && inst_ready;
    assign w_flush    = redirect_valid && (r_state != FAULT);
    assign w_push     = (r_state == RUN) && !redirect_valid && !halt && w_in_range
                        && (!w_full || w_pop);
    assign w_entry    = '{pc: r_fetch_pc, instr: imem_rd};

    assign imem_addr  = r_fetch_pc;
    assign inst_data  = w_head.instr;
    assign inst_pc    = w_head.pc;
    assign fault      = r_fault;
    assign state_o    = r_state;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_fetch_pc <= RESET_PC;
            r_fault    <= 1'b0;
        end else if (r_state != FAULT) begin
            if (redirect_valid) begin
                if (redirect_pc[1:0] != 2'b00) begin
                    r_state <= FAULT;
                    r_fault <= 1'b1;
                end else begin
                    r_state    <= RUN;
                    r_fetch_pc <= redirect_pc;
                end
            end else if (r_state == RUN) begin
                // Leaving RUN after the last word is fetched lets the queue drain.
                if (w_push) begin
                    r_fetch_pc <= r_fetch_pc + 32'(WORD_BYTES);
                    if (r_fetch_pc == LAST_PC) r_state <= END;
                end else if (!w_in_range) begin
                    r_state <= END;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench: streaming, backpressure, redirect, fault, end of memory,
// halt and asynchronous reset.
module tb_fetch_controller;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [64];

    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        fault;
    logic [1:0]  state_o;

    logic        e_reset = 1'b1;
    logic [31:0] e_imem_addr;
    logic [31:0] e_imem_rd;
    logic        e_inst_valid;
    logic [31:0] e_inst_data;
    logic [31:0] e_inst_pc;
    logic        e_inst_ready = 1'b0;
    logic        e_redirect_valid = 1'b0;
    logic [31:0] e_redirect_pc = 32'h0;
    logic        e_halt = 1'b0;
    logic        e_fault;
    logic [1:0]  e_state_o;

    assign imem_rd   = imem[imem_addr[7:2]];
    assign e_imem_rd = imem[e_imem_addr[7:2]];

    fetch_controller #(.DEPTH(4), .MEM_WORDS(64), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .fault(fault), .state_o(state_o)
    );

    fetch_controller #(.DEPTH(4), .MEM_WORDS(4), .RESET_PC(32'h0)) u_dut_end (
        .clk(clk), .reset(e_reset), .imem_addr(e_imem_addr), .imem_rd(e_imem_rd),
        .inst_valid(e_inst_valid), .inst_data(e_inst_data), .inst_pc(e_inst_pc),
        .inst_ready(e_inst_ready), .redirect_valid(e_redirect_valid),
        .redirect_pc(e_redirect_pc), .halt(e_halt), .fault(e_fault),
        .state_o(e_state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 | 32'(i);
        imem[0] = 32'hE04F000F;
        imem[1] = 32'hE2800002;
        imem[2] = 32'hE3A0A040;

        // Streaming
        inst_ready = 1'b1;
        pulse_reset();
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_data", inst_data, 32'h0);
        tick();
        check("s0_valid", 32'(inst_valid), 32'h1);
        check("s0_pc", inst_pc, 32'h0);
        check("s0_data", inst_data, 32'hE04F000F);
        tick();
        check("s1_pc", inst_pc, 32'h4);
        check("s1_data", inst_data, 32'hE2800002);
        tick();
        check("s2_pc", inst_pc, 32'h8);
        check("s2_data", inst_data, 32'hE3A0A040);
        check("s2_addr", imem_addr, 32'hC);

        // Backpressure
        inst_ready = 1'b0;
        pulse_reset();
        repeat (10) tick();
        check("bp_addr_stall", imem_addr, 32'h10);
        check("bp_head_pc", inst_pc, 32'h0);
        check("bp_valid", 32'(inst_valid), 32'h1);
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_drain%0d_valid", k), 32'(inst_valid), 32'h1);
            check($sformatf("bp_drain%0d_pc", k), inst_pc, 32'(4 * k));
            check($sformatf("bp_drain%0d_data", k), inst_data, imem[k]);
            tick();
        end

        // Redirect with 3 entries queued
        inst_ready = 1'b0;
        pulse_reset();
        repeat (3) tick();
        check("rd_pre_addr", imem_addr, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h28;
        tick();
        redirect_valid = 1'b0;
        check("rd_flush_valid", 32'(inst_valid), 32'h0);
        check("rd_addr", imem_addr, 32'h28);
        tick();
        check("rd_new_valid", 32'(inst_valid), 32'h1);
        check("rd_new_pc", inst_pc, 32'h28);
        check("rd_new_data", inst_data, imem[10]);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2A;
        tick();
        redirect_valid = 1'b0;
        check("mis_fault", 32'(fault), 32'h1);
        check("mis_state", 32'(state_o), 32'h2);
        check("mis_valid", 32'(inst_valid), 32'h0);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        check("mis_sticky_fault", 32'(fault), 32'h1);
        check("mis_sticky_state", 32'(state_o), 32'h2);
        check("mis_sticky_valid", 32'(inst_valid), 32'h0);
        reset = 1'b1;
        #1;
        check("mis_rst_fault", 32'(fault), 32'h0);
        check("mis_rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Halt drains the queue without fetching, then async reset mid-cycle
        inst_ready = 1'b0;
        pulse_reset();
        repeat (2) tick();
        check("h_pre_addr", imem_addr, 32'h8);
        halt       = 1'b1;
        inst_ready = 1'b1;
        check("h_d0_pc", inst_pc, 32'h0);
        tick();
        check("h_d1_valid", 32'(inst_valid), 32'h1);
        check("h_d1_pc", inst_pc, 32'h4);
        check("h_d1_addr", imem_addr, 32'h8);
        tick();
        check("h_empty_valid", 32'(inst_valid), 32'h0);
        check("h_empty_addr", imem_addr, 32'h8);
        tick();
        check("h_frozen_addr", imem_addr, 32'h8);
        halt = 1'b0;
        tick();
        check("h_resume_pc", inst_pc, 32'h8);
        check("h_resume_addr", imem_addr, 32'hC);
        #3;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(inst_valid), 32'h0);
        check("ar_addr", imem_addr, 32'h0);
        check("ar_pc", inst_pc, 32'h0);
        check("ar_data", inst_data, 32'h0);
        check("ar_state", 32'(state_o), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // End of memory on the 4-word instance
        e_inst_ready = 1'b1;
        e_reset      = 1'b1;
        @(posedge clk);
        #1;
        e_reset = 1'b0;
        check("e_rst_state", 32'(e_state_o), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("e_d%0d_valid", k), 32'(e_inst_valid), 32'h1);
            check($sformatf("e_d%0d_pc", k), e_inst_pc, 32'(4 * k));
        end
        check("e_state_end", 32'(e_state_o), 32'h1);
        tick();
        check("e_done_valid", 32'(e_inst_valid), 32'h0);
        check("e_done_addr", e_imem_addr, 32'h10);
        tick();
        check("e_idle_valid", 32'(e_inst_valid), 32'h0);
        check("e_idle_state", 32'(e_state_o), 32'h1);
        e_redirect_valid = 1'b1;
        e_redirect_pc    = 32'h0;
        tick();
        e_redirect_valid = 1'b0;
        check("e_rd_state", 32'(e_state_o), 32'h0);
        check("e_rd_addr", e_imem_addr, 32'h0);
        check("e_rd_valid", 32'(e_inst_valid), 32'h0);
        tick();
        check("e_restart_valid", 32'(e_inst_valid), 32'h1);
        check("e_restart_pc", e_inst_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
